// File: rtl/nes_bus_req_pkg.sv
// Shared types and constants for the NES bus-request arbiter: FSM states,
// Avalon register offsets, source encoding and REQ register layout.
package nes_bus_req_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] OFS_REQ  = 2'd0;
    localparam logic [1:0] OFS_DATA = 2'd1;
    localparam logic [1:0] OFS_CTRL = 2'd2;
    localparam logic [1:0] OFS_STAT = 2'd3;

    localparam logic SRC_CPU = 1'b0;
    localparam logic SRC_PPU = 1'b1;

    localparam int REQ_VALID_BIT = 31;
    localparam int REQ_RNW_BIT   = 17;
    localparam int REQ_SRC_BIT   = 16;
    localparam int REQ_ADDR_MSB  = 15;

    // REQ reads as all zeros whenever no transaction is pending.
    function automatic logic [31:0] pack_req(input logic valid, input logic rnw,
                                             input logic src, input logic [15:0] addr);
        logic [31:0] word;
        word = '0;
        if (valid) begin
            word[REQ_VALID_BIT]         = 1'b1;
            word[REQ_RNW_BIT]           = rnw;
            word[REQ_SRC_BIT]           = src;
            word[REQ_ADDR_MSB:0]        = addr;
        end
        return word;
    endfunction

endpackage

// File: rtl/nes_rr_arb2.sv
// Two-input round-robin grant; the last-granted source loses priority.
// The last-grant register only moves when the caller accepts a grant.
module nes_rr_arb2
    import nes_bus_req_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant,
    output logic       grant_src
);

    // One-hot last grant; all-zero after reset so the CPU is favoured.
    logic [1:0] last_reg;
    logic       ppu_first;

    assign ppu_first = last_reg[SRC_CPU];

    always_comb begin
        grant_src = ppu_first ? req[SRC_PPU] : ~req[SRC_CPU];
        grant     = 2'b00;
        if (|req) begin
            grant = grant_src ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_reg <= 2'b00;
        end else if (accept && (|req)) begin
            last_reg <= grant;
        end
    end

endmodule

// File: rtl/nes_bus_req_arbiter.sv
// Latches one CPU/PPU bus request at a time, exposes it to the NIOS II over
// an Avalon-MM slave, and completes it on a software response or a timeout.
module nes_bus_req_arbiter
    import nes_bus_req_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 4096,
    parameter logic [7:0] TIMEOUT_DATA   = 8'hFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq,
    input  logic        cpu_req,
    input  logic        cpu_rnw,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    input  logic        ppu_req,
    input  logic [13:0] ppu_addr,
    output logic        ppu_ack,
    output logic [7:0]  ppu_rdata
);

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_reg;
    state_t      state_next;
    logic        src_reg;
    logic        rnw_reg;
    logic [15:0] addr_reg;
    logic [7:0]  wdata_reg;
    logic [15:0] cnt_reg;
    logic        irq_en_reg;
    logic        timeout_reg;
    logic [7:0]  cpu_rdata_reg;
    logic [7:0]  ppu_rdata_reg;
    logic [31:0] readdata_reg;
    logic [31:0] readdata_next;

    logic        wr_en;
    logic        rd_en;
    logic        resp_wr;
    logic        expire;
    logic        valid;
    logic        accept;
    logic [1:0]  grant;
    logic        grant_src;
    logic        unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign rd_en        = chipselect & write_n;
    assign valid        = (state_reg == WAIT);
    assign resp_wr      = valid && wr_en && (address == OFS_DATA);
    assign expire       = valid && (cnt_reg == CNT_LAST);
    assign accept       = (state_reg == IDLE) && (cpu_req || ppu_req);
    assign unused_wdata = ^writedata[31:8];

    nes_rr_arb2 u_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       ({ppu_req, cpu_req}),
        .accept    (accept),
        .grant     (grant),
        .grant_src (grant_src)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = WAIT;
            WAIT:    if (resp_wr || expire) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            src_reg       <= SRC_CPU;
            rnw_reg       <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            cnt_reg       <= '0;
            cpu_rdata_reg <= '0;
            ppu_rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && accept) begin
                src_reg   <= grant_src;
                rnw_reg   <= grant_src ? 1'b1 : cpu_rnw;
                addr_reg  <= grant_src ? {2'b00, ppu_addr} : cpu_addr;
                wdata_reg <= grant_src ? 8'h00 : cpu_wdata;
                cnt_reg   <= '0;
            end else if (valid) begin
                // Software response takes precedence over a simultaneous expiry.
                if (resp_wr || expire) begin
                    if (src_reg == SRC_PPU) begin
                        ppu_rdata_reg <= resp_wr ? writedata[7:0] : TIMEOUT_DATA;
                    end else begin
                        cpu_rdata_reg <= resp_wr ? writedata[7:0] : TIMEOUT_DATA;
                    end
                end else begin
                    cnt_reg <= cnt_reg + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en_reg  <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            if (wr_en && address == OFS_CTRL) begin
                irq_en_reg <= writedata[0];
            end
            // A timeout in the same cycle as a clear leaves the flag set.
            if (expire && !resp_wr) begin
                timeout_reg <= 1'b1;
            end else if (wr_en && address == OFS_STAT && writedata[0]) begin
                timeout_reg <= 1'b0;
            end
        end
    end

    always_comb begin
        readdata_next = '0;
        if (rd_en) begin
            case (address)
                OFS_REQ:  readdata_next = pack_req(valid, rnw_reg, src_reg, addr_reg);
                OFS_DATA: readdata_next = {24'h0, wdata_reg};
                OFS_CTRL: readdata_next = {31'h0, irq_en_reg};
                OFS_STAT: readdata_next = {31'h0, timeout_reg};
                default:  readdata_next = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_reg <= '0;
        end else begin
            readdata_reg <= readdata_next;
        end
    end

    assign readdata  = readdata_reg;
    assign irq       = valid & irq_en_reg;
    assign cpu_ack   = (state_reg == RESP) && (src_reg == SRC_CPU);
    assign ppu_ack   = (state_reg == RESP) && (src_reg == SRC_PPU);
    assign cpu_rdata = cpu_rdata_reg;
    assign ppu_rdata = ppu_rdata_reg;

endmodule
